// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM encoding,
// default word geometry, the NOP word and endianness selectors.
package imem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } imem_state_e;

  localparam int DEF_NB_BYTE        = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int NB_INSTRUCTION     = DEF_NB_BYTE * DEF_BYTES_PER_WORD;

  localparam logic [NB_INSTRUCTION-1:0] NOP_WORD = '0;

  localparam int ENDIAN_LITTLE = 0;
  localparam int ENDIAN_BIG    = 1;

endpackage

// File: rtl/imem_word_assemble.sv
// Orders BYTES_PER_WORD cells (index 0 = lowest address) into one
// instruction word according to the selected endianness.
module imem_word_assemble
  import imem_pkg::*;
#(
  parameter int NB_BYTE        = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int BIG_ENDIAN     = ENDIAN_BIG
) (
  input  logic [BYTES_PER_WORD-1:0][NB_BYTE-1:0] i_bytes,
  output logic [NB_BYTE*BYTES_PER_WORD-1:0]      o_word
);

  always_comb begin
    o_word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (BIG_ENDIAN == ENDIAN_BIG) begin
        o_word[(BYTES_PER_WORD-1-i)*NB_BYTE +: NB_BYTE] = i_bytes[i];
      end else begin
        o_word[i*NB_BYTE +: NB_BYTE] = i_bytes[i];
      end
    end
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Byte-addressed instruction memory with a byte-stream loader, a hardware
// clear sweep and a registered read path carrying valid and error flags.
module instruction_memory_loadable
  import imem_pkg::*;
#(
  parameter int    NB_BYTE        = 8,
  parameter int    BYTES_PER_WORD = 4,
  parameter int    MEMORY_DEPTH   = 256,
  parameter int    NB_ADDR        = 32,
  parameter int    OUTPUT_REG     = 0,
  parameter int    BIG_ENDIAN     = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_read_enable,
  input  logic [NB_ADDR-1:0]                i_read_addr,
  output logic [NB_BYTE*BYTES_PER_WORD-1:0] o_read_data,
  output logic                              o_read_valid,
  output logic                              o_misaligned,
  output logic                              o_out_of_range,
  input  logic                              i_load_restart,
  input  logic                              i_load_valid,
  input  logic [NB_BYTE-1:0]                i_load_byte,
  output logic [$clog2(MEMORY_DEPTH):0]     o_load_count,
  output logic                              o_load_overflow,
  input  logic                              i_clear,
  output logic                              o_busy
);

  localparam int NB_INSTR = NB_BYTE * BYTES_PER_WORD;
  localparam int NB_IDX   = $clog2(MEMORY_DEPTH);
  localparam int NB_PTR   = NB_IDX + 1;
  localparam int NB_SUM   = NB_ADDR + 1;

  localparam logic [NB_PTR-1:0] DEPTH_P     = NB_PTR'(MEMORY_DEPTH);
  localparam logic [NB_PTR-1:0] LAST_WORD_P = NB_PTR'(MEMORY_DEPTH - BYTES_PER_WORD);
  localparam logic [NB_PTR-1:0] BPW_P       = NB_PTR'(BYTES_PER_WORD);

  logic [NB_BYTE-1:0] mem [MEMORY_DEPTH];

  imem_state_e       state_q, state_d;
  logic [NB_PTR-1:0] clr_ptr_q, clr_ptr_d;
  logic [NB_PTR-1:0] load_ptr_q, load_ptr_d;
  logic              ovf_q, ovf_d;
  logic              ld_we, clr_we;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    load_ptr_d = load_ptr_q;
    ovf_d      = ovf_q;
    ld_we      = 1'b0;
    clr_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          state_d    = ST_CLEAR;
          clr_ptr_d  = '0;
          load_ptr_d = '0;
          ovf_d      = 1'b0;
        end else if (i_load_restart) begin
          load_ptr_d = '0;
          ovf_d      = 1'b0;
        end else if (i_load_valid) begin
          if (load_ptr_q < DEPTH_P) begin
            ld_we      = 1'b1;
            load_ptr_d = load_ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr_q == LAST_WORD_P) begin
          state_d = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + BPW_P;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      clr_ptr_q  <= '0;
      load_ptr_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      load_ptr_q <= load_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is deliberately outside reset so a reset never disturbs contents.
  always_ff @(posedge i_clock) begin
    if (clr_we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        mem[clr_ptr_q[NB_IDX-1:0] + NB_IDX'(i)] <= '0;
      end
    end
    if (ld_we) begin
      mem[load_ptr_q[NB_IDX-1:0]] <= i_load_byte;
    end
  end

  assign o_load_count    = load_ptr_q;
  assign o_load_overflow = ovf_q;
  assign o_busy          = (state_q == ST_CLEAR);

  // Read stage p0: address decode and word assembly from current contents
  logic                                     rd_accept, rd_mis, rd_oor;
  logic [NB_SUM-1:0]                        rd_end;
  logic [BYTES_PER_WORD-1:0][NB_BYTE-1:0]   rd_bytes;
  logic [NB_INSTR-1:0]                      asm_word, rd_word;

  assign rd_accept = i_read_enable && (state_q == ST_IDLE);
  assign rd_end    = {1'b0, i_read_addr} + NB_SUM'(BYTES_PER_WORD - 1);
  assign rd_oor    = (rd_end >= NB_SUM'(MEMORY_DEPTH));
  assign rd_mis    = ((i_read_addr % NB_ADDR'(BYTES_PER_WORD)) != '0);

  always_comb begin
    rd_bytes = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      rd_bytes[i] = mem[i_read_addr[NB_IDX-1:0] + NB_IDX'(i)];
    end
  end

  imem_word_assemble #(
    .NB_BYTE        (NB_BYTE),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BIG_ENDIAN     (BIG_ENDIAN)
  ) u_word_assemble (
    .i_bytes (rd_bytes),
    .o_word  (asm_word)
  );

  assign rd_word = rd_oor ? NB_INSTR'(NOP_WORD) : asm_word;

  // Read stage p1: registered on the accepting edge
  logic                vld_p1_q, vld_p1_d;
  logic [NB_INSTR-1:0] data_p1_q, data_p1_d;
  logic                mis_p1_q, mis_p1_d;
  logic                oor_p1_q, oor_p1_d;

  always_comb begin
    vld_p1_d  = rd_accept;
    data_p1_d = rd_accept ? rd_word : data_p1_q;
    mis_p1_d  = rd_accept && rd_mis;
    oor_p1_d  = rd_accept && rd_oor;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      mis_p1_q  <= 1'b0;
      oor_p1_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      mis_p1_q  <= mis_p1_d;
      oor_p1_q  <= oor_p1_d;
    end
  end

  // Read stage p2: optional extra output register
  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic                vld_p2_q, vld_p2_d;
      logic [NB_INSTR-1:0] data_p2_q, data_p2_d;
      logic                mis_p2_q, mis_p2_d;
      logic                oor_p2_q, oor_p2_d;

      always_comb begin
        vld_p2_d  = vld_p1_q;
        data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
        mis_p2_d  = mis_p1_q;
        oor_p2_d  = oor_p1_q;
      end

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          vld_p2_q  <= 1'b0;
          data_p2_q <= '0;
          mis_p2_q  <= 1'b0;
          oor_p2_q  <= 1'b0;
        end else begin
          vld_p2_q  <= vld_p2_d;
          data_p2_q <= data_p2_d;
          mis_p2_q  <= mis_p2_d;
          oor_p2_q  <= oor_p2_d;
        end
      end

      assign o_read_valid   = vld_p2_q;
      assign o_read_data    = data_p2_q;
      assign o_misaligned   = mis_p2_q;
      assign o_out_of_range = oor_p2_q;
    end else begin : g_out_direct
      assign o_read_valid   = vld_p1_q;
      assign o_read_data    = data_p1_q;
      assign o_misaligned   = mis_p1_q;
      assign o_out_of_range = oor_p1_q;
    end
  endgenerate

endmodule
